mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the CPU's memory interface: 2^ADDR_W x DATA_W word-addressed store.
- Two synchronous read ports (instruction fetch, data load) and one write port.
- Write-first forwarding when a read and a write hit the same address in the same cycle.
- After reset, a loader FSM fills memory from a byte stream before the CPU side is enabled; `busy` holds the CPU off until loading completes.

Parameters:
ADDR_W, 15, word address width (byte address bits [15:1])
DATA_W, 16, word width; loader assumes DATA_W = 16 (two bytes per word)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
raddr0  in  ADDR_W  read port 0 word address (fetch)
rdata0  out  DATA_W  read port 0 data, registered
raddr1  in  ADDR_W  read port 1 word address (load)
rdata1  out  DATA_W  read port 1 data, registered
wen  in  1  write enable
waddr  in  ADDR_W  write word address
wdata  in  DATA_W  write data
load_valid  in  1  loader byte valid
load_byte  in  8  loader byte
load_last  in  1  final byte of image, qualified by load_valid
load_ready  out  1  loader accepts bytes
busy  out  1  high while loading; CPU must not rely on ports

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = LOAD, ptr = 0, phase = 0, lo_byte = 0
  - rdata0 = rdata1 = 0, busy = 1, load_ready = 1
  - Memory contents are not cleared.
- States:
  - LOAD: load_ready = 1, busy = 1.
  - RUN: load_ready = 0, busy = 0. RUN is terminal until the next reset.
- LOAD handshake: a byte is accepted on an edge where load_valid & load_ready.
  - phase 0: latch lo_byte, set phase = 1.
  - phase 1: write mem[ptr] = {load_byte, lo_byte}, ptr += 1, phase = 0. Bytes are little-endian.
  - load_last on a phase-1 byte: write the word, then go to RUN.
  - load_last on a phase-0 byte: write mem[ptr] = {8'h00, load_byte}, then go to RUN.
  - Accepted byte completes the word at ptr = all-ones: write the word and go to RUN; ptr does not wrap.
  - load_valid low: no state change. Bytes are never dropped while load_ready = 1.
- LOAD, CPU side: wen is ignored (no write); rdata0/rdata1 hold 0.
- RUN reads: rdataN <= mem[raddrN] at each edge; 1-cycle latency; both ports independent; reading the same address on both ports is legal.
- RUN write: mem[waddr] <= wdata on an edge with wen = 1.
- Collision: if wen and raddrN == waddr in the same cycle, rdataN <= wdata (write-first). Applies to each port independently.
- Back-to-back: a write at edge k followed by a read of the same address issued in cycle k+1 returns the new data at edge k+1.
- Reset asserted mid-LOAD or mid-RUN: immediate return to LOAD, ptr = 0, phase = 0, outputs at reset values. Memory keeps prior contents; the in-flight partial word is discarded.
- No X-propagation requirement on unwritten locations; the bench must not read unloaded, unwritten addresses.

Decomposition:
- Shared package mem_pkg: ADDR_W, DATA_W, BYTES_PER_WORD = 2, state enum {ST_LOAD, ST_RUN}.
- Sub-module mem_loader:
  - Contains: loader FSM, ptr, phase, lo_byte.
  - Outputs: internal write request (ld_wen, ld_waddr, ld_wdata) and done.
- Top level: storage array, read registers, collision forwarding, write mux (loader in LOAD, CPU in RUN).

Test Plan:
- Reset, stream bytes 34 12 78 56 BC 9A with load_last on 9A -> busy falls the cycle after 9A is accepted; reads of 0,1,2 return 1234, 5678, 9ABC one cycle after address.
- Odd image: stream AA BB CC, load_last on CC -> mem[1] = 00CC; busy = 0; load_ready = 0.
- RUN: wen = 1, waddr = 5, wdata = BEEF with raddr0 = raddr1 = 5 in the same cycle -> rdata0 = rdata1 = BEEF next cycle; the following read of 5 also returns BEEF.
- Dual read: raddr0 = 0, raddr1 = 2 each cycle with the write port idle -> rdata0 = 1234, rdata1 = 9ABC each cycle with 1-cycle latency; the write port never disturbs the other address.
- During LOAD, drive wen = 1, waddr = 0, wdata = FFFF -> after load completes, mem[0] still holds the loaded value; rdata stays 0 while busy.
- Assert rst_n low mid-load after 3 bytes, then reload 11 22 with last -> mem[0] = 2211; busy = 1 during reset; rdata = 0 asynchronously on rst_n fall.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its boot-image loader.
package mem_pkg;

    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 16;
    localparam int BYTES_PER_WORD = 2;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

endpackage

// File: rtl/mem_loader.sv
// Boot loader: packs a little-endian byte stream into words and issues
// write requests until the last byte arrives or the top word is filled.
module mem_loader #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              ld_wen,
    output logic [ADDR_W-1:0] ld_waddr,
    output logic [DATA_W-1:0] ld_wdata,
    output logic              done
);
    import mem_pkg::*;

    localparam int BYTE_W = DATA_W / BYTES_PER_WORD;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              phase, phase_nx;
    logic [BYTE_W-1:0] lo_byte, lo_byte_nx;

    // Loader state register; memory contents are untouched by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            ptr     <= '0;
            phase   <= 1'b0;
            lo_byte <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            phase   <= phase_nx;
            lo_byte <= lo_byte_nx;
        end
    end

    // Byte acceptance, word assembly and write request generation.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        phase_nx   = phase;
        lo_byte_nx = lo_byte;
        ld_wen     = 1'b0;
        ld_waddr   = ptr;
        ld_wdata   = phase ? DATA_W'({load_byte, lo_byte}) : DATA_W'({8'h00, load_byte});
        done       = (state == ST_RUN);

        if (state == ST_LOAD && load_valid) begin
            if (!phase && !load_last) begin
                lo_byte_nx = load_byte;
                phase_nx   = 1'b1;
            end else begin
                // A completed word, or a lone trailing byte zero-extended.
                ld_wen   = 1'b1;
                phase_nx = 1'b0;
                if (load_last || ptr == '1) begin
                    state_nx = ST_RUN;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word store with two registered read ports, one
// write port with write-first forwarding, filled at boot by mem_loader.
module mem_responder #(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    input  logic              load_last,
    output logic              load_ready,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ld_wen;
    logic [ADDR_W-1:0] ld_waddr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_done;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    mem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .ld_wen     (ld_wen),
        .ld_waddr   (ld_waddr),
        .ld_wdata   (ld_wdata),
        .done       (ld_done)
    );

    assign busy       = !ld_done;
    assign load_ready = !ld_done;

    // Write port owner: loader while loading, CPU afterwards.
    always_comb begin
        mem_we    = ld_done ? wen   : ld_wen;
        mem_waddr = ld_done ? waddr : ld_waddr;
        mem_wdata = ld_done ? wdata : ld_wdata;
    end

    // Storage array, no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered reads with write-first forwarding per port; held at 0 while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (ld_done) begin
            rdata0 <= (wen && raddr0 == waddr) ? wdata : mem[raddr0];
            rdata1 <= (wen && raddr1 == waddr) ? wdata : mem[raddr1];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] raddr0, raddr1, waddr;
    logic [15:0] rdata0, rdata1, wdata;
    logic        wen, load_valid, load_last, load_ready, busy;
    logic [7:0]  load_byte;

    // Small instance used to reach the top-of-memory fill boundary quickly.
    logic [2:0]  s_raddr0, s_raddr1, s_waddr;
    logic [15:0] s_rdata0, s_rdata1, s_wdata;
    logic        s_wen, s_load_valid, s_load_last, s_load_ready, s_busy;
    logic [7:0]  s_load_byte;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] model [int];
    logic [14:0] known_q [$];
    logic [7:0]  img [$];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready), .busy(busy)
    );

    mem_responder #(.ADDR_W(3), .DATA_W(16)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .raddr0(s_raddr0), .rdata0(s_rdata0), .raddr1(s_raddr1), .rdata1(s_rdata1),
        .wen(s_wen), .waddr(s_waddr), .wdata(s_wdata),
        .load_valid(s_load_valid), .load_byte(s_load_byte), .load_last(s_load_last),
        .load_ready(s_load_ready), .busy(s_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic note_known(input logic [14:0] a);
        if (!model.exists(int'(a))) known_q.push_back(a);
    endtask

    // Streams img with random idle gaps; model words come from byte pairs.
    task automatic load_image();
        int gaps;
        for (int i = 0; i < img.size(); i++) begin
            if (i % 2 == 1) begin
                note_known(15'(i / 2));
                model[i / 2] = 16'(int'(img[i]) * 256 + int'(img[i-1]));
            end else if (i == img.size() - 1) begin
                note_known(15'(i / 2));
                model[i / 2] = 16'(img[i]);
            end
        end
        for (int i = 0; i < img.size(); i++) begin
            gaps = $urandom_range(0, 2);
            load_valid = 1'b0;
            repeat (gaps) begin
                step();
                check("busy_idle", busy, 1);
            end
            check("load_ready_on", load_ready, 1);
            load_valid = 1'b1;
            load_byte  = img[i];
            load_last  = (i == img.size() - 1);
            step();
            load_valid = 1'b0;
            load_last  = 1'b0;
            if (i == img.size() - 1) begin
                check("busy_done", busy, 0);
                check("load_ready_done", load_ready, 0);
            end else begin
                check("busy_loading", busy, 1);
                check("rdata0_loading", rdata0, 0);
            end
        end
    endtask

    task automatic read_pair(input logic [14:0] a0, input logic [14:0] a1);
        raddr0 = a0;
        raddr1 = a1;
        step();
        check("rd0", rdata0, model[int'(a0)]);
        check("rd1", rdata1, model[int'(a1)]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_busy", busy, 1);
        check("rst_load_ready", load_ready, 1);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] smodel [8];
        logic [7:0]  sb [16];
        logic [15:0] e0, e1;
        logic [14:0] a0, a1;

        rst_n = 1'b0;
        raddr0 = '0; raddr1 = '0;
        wen = 1'b1; waddr = '0; wdata = 16'hFFFF;   // must be ignored while loading
        load_valid = 1'b0; load_byte = '0; load_last = 1'b0;
        s_raddr0 = '0; s_raddr1 = '0; s_wen = 1'b0; s_waddr = '0; s_wdata = '0;
        s_load_valid = 1'b0; s_load_byte = '0; s_load_last = 1'b0;
        step();
        check("reset_rdata0", rdata0, 0);
        check("reset_rdata1", rdata1, 0);
        check("reset_busy", busy, 1);
        check("reset_load_ready", load_ready, 1);
        step();
        rst_n = 1'b1;

        // Small instance: 16 bytes fill all 8 words, then loading stops without load_last.
        for (int i = 0; i < 16; i++) begin
            sb[i] = 8'($urandom);
            s_load_valid = 1'b1;
            s_load_byte  = sb[i];
            step();
            check("s_busy", s_busy, (i == 15) ? 0 : 1);
            check("main_idle_busy", busy, 1);
        end
        s_load_valid = 1'b0;
        check("s_load_ready_full", s_load_ready, 0);
        for (int w = 0; w < 8; w++) smodel[w] = {sb[2*w+1], sb[2*w]};
        for (int w = 0; w < 8; w++) begin
            s_raddr0 = 3'(w);
            s_raddr1 = 3'(7 - w);
            step();
            check("s_rd0", s_rdata0, smodel[w]);
            check("s_rd1", s_rdata1, smodel[7 - w]);
        end

        // Main image; wen=1 held throughout must not touch memory.
        img = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        load_image();
        wen = 1'b0;
        read_pair(15'd0, 15'd1);
        check("img_word0", rdata0, 16'h1234);
        check("img_word1", rdata1, 16'h5678);
        read_pair(15'd2, 15'd2);
        check("img_word2", rdata0, 16'h9ABC);

        // Same-cycle write and dual read of one address: write-first.
        raddr0 = 15'd5; raddr1 = 15'd5;
        wen = 1'b1; waddr = 15'd5; wdata = 16'hBEEF;
        step();
        check("coll_rd0", rdata0, 16'hBEEF);
        check("coll_rd1", rdata1, 16'hBEEF);
        note_known(15'd5);
        model[5] = 16'hBEEF;
        wen = 1'b0;
        step();
        check("after_coll_rd0", rdata0, 16'hBEEF);

        // Dual reads while the write port is busy elsewhere.
        for (int i = 0; i < 4; i++) begin
            raddr0 = 15'd0; raddr1 = 15'd2;
            wen = 1'b1; waddr = 15'($urandom_range(8, 31)); wdata = 16'($urandom);
            step();
            check("dual_rd0", rdata0, 16'h1234);
            check("dual_rd1", rdata1, 16'h9ABC);
            note_known(waddr);
            model[int'(waddr)] = wdata;
        end
        wen = 1'b0;

        // Random run traffic against the word model.
        for (int i = 0; i < 300; i++) begin
            a0 = known_q[$urandom_range(0, known_q.size() - 1)];
            a1 = known_q[$urandom_range(0, known_q.size() - 1)];
            wen   = 1'($urandom_range(0, 1));
            waddr = ($urandom_range(0, 2) == 0) ? a0 : 15'($urandom_range(0, 31));
            wdata = 16'($urandom);
            raddr0 = a0; raddr1 = a1;
            e0 = (wen && waddr == a0) ? wdata : model[int'(a0)];
            e1 = (wen && waddr == a1) ? wdata : model[int'(a1)];
            step();
            check("rand_rd0", rdata0, e0);
            check("rand_rd1", rdata1, e1);
            if (wen) begin
                note_known(waddr);
                model[int'(waddr)] = wdata;
            end
        end
        wen = 1'b0;

        // Reset mid-load: partial word discarded, memory retained.
        read_pair(15'd0, 15'd1);
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_byte = img[i];
            step();
        end
        load_valid = 1'b0;
        model[0] = 16'hBBAA;
        do_reset();
        img = '{8'h11, 8'h22};
        load_image();
        read_pair(15'd0, 15'd1);
        check("reload_word0", rdata0, 16'h2211);

        // Odd-length image: trailing byte zero-extended.
        do_reset();
        img = '{8'hAA, 8'hBB, 8'hCC};
        load_image();
        read_pair(15'd0, 15'd1);
        check("odd_word1", rdata1, 16'h00CC);
        read_pair(15'd2, 15'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
